// File: rtl/multicycle_addsub_if.sv
// Handshake and operand/result bundle for the sliced adder/subtractor.
// The master side issues operations and the slave side (the arithmetic unit) answers them.
interface multicycle_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/multicycle_addsub.sv
// Sequential adder/subtractor that walks the operands CHUNK bits per clock, LSB slice first.
// Subtraction is performed as a + ~b + 1, so cout=1 means "no borrow".
// The s/cout/ovf outputs are only updated when the last slice completes.
module multicycle_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  multicycle_addsub_if.slave  bus
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NCH - 1);

  // Reject slice sizes that do not tile the operand width.
  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("multicycle_addsub: CHUNK must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   slice_sum;
  logic             msb_carry_in;

  // Slice datapath plus the IDLE/RUN/DONE sequencing; every state element gets its next value here.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    k_d      = k_q;
    shadow_d = shadow_q;
    s_d      = s_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    a_sl     = '0;
    b_sl     = '0;

    for (int i = 0; i < NCH; i++) begin
      if (k_q == KW'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        b_sl = b_q[i*CHUNK +: CHUNK];
      end
    end

    slice_sum    = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
    msb_carry_in = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ slice_sum[CHUNK-1];

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          k_d     = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        carry_d = slice_sum[CHUNK];
        for (int i = 0; i < NCH; i++) begin
          if (k_q == KW'(i)) begin
            shadow_d[i*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
          end
        end
        k_d = k_q + KW'(1);
        if (k_q == LAST_K) begin
          s_d     = shadow_d;
          cout_d  = slice_sum[CHUNK];
          ovf_d   = msb_carry_in ^ slice_sum[CHUNK];
          k_d     = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // All state, including the registered busy/done flags, updates here; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      k_q      <= '0;
      shadow_q <= '0;
      s_q      <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      k_q      <= k_d;
      shadow_q <= shadow_d;
      s_q      <= s_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_multicycle_addsub.sv
// Bench for the sliced adder/subtractor: three configurations (8/2, 5/1, 8/8) share one clock
// and reset, and a per-instance queue of expected results is checked whenever done pulses.
module tb_multicycle_addsub;

  typedef struct packed {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  multicycle_addsub_if #(.WIDTH(8)) bus0 ();
  multicycle_addsub_if #(.WIDTH(5)) bus1 ();
  multicycle_addsub_if #(.WIDTH(8)) bus2 ();

  multicycle_addsub #(.WIDTH(8), .CHUNK(2)) u_w8c2 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  multicycle_addsub #(.WIDTH(5), .CHUNK(1)) u_w5c1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  multicycle_addsub #(.WIDTH(8), .CHUNK(8)) u_w8c8 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // Free-running clock and a cycle counter that advances on every rising edge.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Abort rather than hang if the stimulus ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int nch(input int d);
    case (d)
      0:       return 4;
      1:       return 5;
      default: return 1;
    endcase
  endfunction

  function automatic int width_of(input int d);
    return (d == 1) ? 5 : 8;
  endfunction

  // Reference arithmetic, written from the unsigned/signed definitions.
  function automatic exp_t model(input int w, input bit sub, input int a, input int b, input bit cin);
    exp_t e;
    int mask, bb, full, sa, sb, ss;
    mask  = (1 << w) - 1;
    bb    = sub ? (~b & mask) : (b & mask);
    full  = (a & mask) + bb + (sub ? 1 : int'(cin));
    e.s   = 8'(full & mask);
    e.cout = 1'((full >> w) & 1);
    sa    = (a >> (w - 1)) & 1;
    sb    = (bb >> (w - 1)) & 1;
    ss    = (full >> (w - 1)) & 1;
    e.ovf = (sa == sb) && (ss != sa);
    e.cyc = 0;
    return e;
  endfunction

  task automatic driveInputs(input int d, input bit st, input bit sub, input int a, input int b, input bit cin);
    case (d)
      0: begin bus0.start = st; bus0.sub = sub; bus0.a = 8'(a); bus0.b = 8'(b); bus0.cin = cin; end
      1: begin bus1.start = st; bus1.sub = sub; bus1.a = 5'(a); bus1.b = 5'(b); bus1.cin = cin; end
      default: begin bus2.start = st; bus2.sub = sub; bus2.a = 8'(a); bus2.b = 8'(b); bus2.cin = cin; end
    endcase
  endtask

  task automatic releaseStart(input int d);
    case (d)
      0:       bus0.start = 1'b0;
      1:       bus1.start = 1'b0;
      default: bus2.start = 1'b0;
    endcase
  endtask

  // Called just after a falling edge: raise start and record the result expected NCH edges after acceptance.
  task automatic issueOp(input int d, input bit sub, input int a, input int b, input bit cin);
    exp_t e;
    driveInputs(d, 1'b1, sub, a, b, cin);
    e = model(width_of(d), sub, a, b, cin);
    e.cyc = cyc + 1 + nch(d);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // One full operation; returns at the falling edge where done is high so the next call is back-to-back.
  task automatic applyStimulus(input int d, input bit sub, input int a, input int b, input bit cin);
    issueOp(d, sub, a, b, cin);
    @(negedge clk);
    releaseStart(d);
    repeat (nch(d)) @(negedge clk);
  endtask

  task automatic scoreResult(input int d, input logic [31:0] s_obs, input logic cout_obs, input logic ovf_obs);
    exp_t e;
    int   sz;
    case (d)
      0:       sz = q0.size();
      1:       sz = q1.size();
      default: sz = q2.size();
    endcase
    checkOutput($sformatf("done_has_request_d%0d", d), 32'(sz > 0), 32'd1);
    if (sz > 0) begin
      case (d)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      checkOutput($sformatf("s_d%0d", d), s_obs, 32'(e.s));
      checkOutput($sformatf("cout_d%0d", d), 32'(cout_obs), 32'(e.cout));
      checkOutput($sformatf("ovf_d%0d", d), 32'(ovf_obs), 32'(e.ovf));
      checkOutput($sformatf("latency_d%0d", d), 32'(cyc), 32'(e.cyc));
    end
  endtask

  // Result monitors: every done pulse must match the oldest outstanding request.
  always @(negedge clk) if (rst_n === 1'b1 && bus0.done === 1'b1) scoreResult(0, 32'(bus0.s), bus0.cout, bus0.ovf);
  always @(negedge clk) if (rst_n === 1'b1 && bus1.done === 1'b1) scoreResult(1, 32'(bus1.s), bus1.cout, bus1.ovf);
  always @(negedge clk) if (rst_n === 1'b1 && bus2.done === 1'b1) scoreResult(2, 32'(bus2.s), bus2.cout, bus2.ovf);

  // Directed and exhaustive stimulus sequence.
  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) driveInputs(d, 1'b0, 1'b0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(bus0.busy), 32'd0);
    checkOutput("rst_done", 32'(bus0.done), 32'd0);
    checkOutput("rst_s", 32'(bus0.s), 32'd0);
    checkOutput("rst_cout", 32'(bus0.cout), 32'd0);
    checkOutput("rst_ovf", 32'(bus0.ovf), 32'd0);
    checkOutput("rst_s_d1", 32'(bus1.s), 32'd0);
    checkOutput("rst_busy_d2", 32'(bus2.busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] add 200+100 with busy/done timing");
    issueOp(0, 1'b0, 200, 100, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) releaseStart(0);
      checkOutput($sformatf("busy_t%0d", i), 32'(bus0.busy), 32'(i <= 4));
      checkOutput($sformatf("done_t%0d", i), 32'(bus0.done), 32'(i == 5));
    end
    @(negedge clk);
    checkOutput("done_single_pulse", 32'(bus0.done), 32'd0);
    checkOutput("s_holds_in_idle", 32'(bus0.s), 32'd44);

    $display("[TB] back-to-back add/sub sequence");
    applyStimulus(0, 1'b0, 127, 1, 1'b0);
    applyStimulus(0, 1'b1, 5, 7, 1'b0);
    applyStimulus(0, 1'b1, 8'h80, 1, 1'b1);
    @(negedge clk);

    $display("[TB] start during RUN is ignored");
    issueOp(0, 1'b0, 1, 1, 1'b0);
    @(negedge clk);
    releaseStart(0);
    @(negedge clk);
    driveInputs(0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0);
    @(negedge clk);
    releaseStart(0);
    checkOutput("s_holds_during_run", 32'(bus0.s), 32'h7F);
    repeat (2) @(negedge clk);
    repeat (4) @(negedge clk);

    $display("[TB] asynchronous reset mid-operation");
    issueOp(0, 1'b0, 8'h55, 8'h11, 1'b0);
    @(negedge clk);
    releaseStart(0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(bus0.busy), 32'd0);
    checkOutput("arst_done", 32'(bus0.done), 32'd0);
    checkOutput("arst_s", 32'(bus0.s), 32'd0);
    checkOutput("arst_cout", 32'(bus0.cout), 32'd0);
    checkOutput("arst_ovf", 32'(bus0.ovf), 32'd0);
    q0.delete();
    #4;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    applyStimulus(0, 1'b0, 3, 4, 1'b0);
    @(negedge clk);

    $display("[TB] single-slice configuration");
    applyStimulus(2, 1'b0, 8'hFF, 8'h01, 1'b1);
    @(negedge clk);

    $display("[TB] exhaustive 5-bit add and subtract");
    for (int a = 0; a < 32; a++)
      for (int b = 0; b < 32; b++)
        for (int c = 0; c < 2; c++)
          applyStimulus(1, 1'b0, a, b, c[0]);
    for (int a = 0; a < 32; a++)
      for (int b = 0; b < 32; b++)
        applyStimulus(1, 1'b1, a, b, 1'($urandom_range(0, 1)));
    repeat (3) @(negedge clk);

    checkOutput("pending_d0", 32'(q0.size()), 32'd0);
    checkOutput("pending_d1", 32'(q1.size()), 32'd0);
    checkOutput("pending_d2", 32'(q2.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
